// File: rtl/led_seq_pkg.sv
// Shared types and default sizes for the LED RGB pattern sequencer.
package led_seq_pkg;

  localparam int unsigned SEQ_NUM_STEPS = 16;
  localparam int unsigned SEQ_DUR_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [2:0]           enable;
    logic [2:0]           mode;
    logic [2:0]           hold;
    logic [SEQ_DUR_W-1:0] duration;
    logic [SEQ_DUR_W-1:0] dwell;
  } seq_step_t;

endpackage

// File: rtl/led_seq_step_ram.sv
// Step table: one write port, one registered read port (distributed RAM).
module led_seq_step_ram
  import led_seq_pkg::*;
#(
  parameter int unsigned  DEPTH = SEQ_NUM_STEPS,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  seq_step_t     wr_data,
  input  logic [AW-1:0] rd_addr,
  output seq_step_t     rd_data
);

  seq_step_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/led_rgb_sequencer.sv
// Autonomous step-table sequencer driving the led_rgb control inputs.
// Optional LED_SEQ_PAUSE_EN adds a pause input that freezes RUN.
module led_rgb_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned  NUM_STEPS = SEQ_NUM_STEPS,
  parameter int unsigned  DUR_W     = SEQ_DUR_W,
  localparam int unsigned IDX_W     = $clog2(NUM_STEPS),
  localparam int unsigned CNT_W     = IDX_W + 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             tbl_wr_en,
  input  logic [IDX_W-1:0] tbl_wr_addr,
  input  logic [2:0]       tbl_wr_enable,
  input  logic [2:0]       tbl_wr_mode,
  input  logic [2:0]       tbl_wr_hold,
  input  logic [DUR_W-1:0] tbl_wr_duration,
  input  logic [DUR_W-1:0] tbl_wr_dwell,
  output logic             tbl_wr_err,
  input  logic [CNT_W-1:0] num_steps,
  input  logic [15:0]      loops,
  input  logic             start,
  input  logic             stop,
`ifdef LED_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [IDX_W-1:0] cur_step,
  output logic             mode_r,
  output logic             mode_g,
  output logic             mode_b,
  output logic             enable_r,
  output logic             enable_g,
  output logic             enable_b,
  output logic             holded_r,
  output logic             holded_g,
  output logic             holded_b,
  output logic [DUR_W-1:0] duration_r,
  output logic [DUR_W-1:0] duration_g,
  output logic [DUR_W-1:0] duration_b
);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] cur_q, cur_d, nxt_q, nxt_d;
  logic [CNT_W-1:0] ns_q, ns_d;
  logic [15:0]      loops_q, loops_d, loop_cnt_q, loop_cnt_d;
  logic [DUR_W-1:0] dwell_q, dwell_d, dur_q, dur_d;
  logic [2:0]       en_q, en_d, mode_q, mode_d, hold_q, hold_d;
  logic             busy_q, busy_d, done_q, done_d, abort_q, abort_d;
  logic             wr_err_q, wr_err_d;

  seq_step_t        wr_step_c, ram_q;
  logic [CNT_W-1:0] ns_clamp_c;
  logic [DUR_W-1:0] step_dur_c, step_dw_raw_c, step_dwell_c;
  logic             wr_ok_c, last_step_c, more_loops_c, pause_c;

`ifdef LED_SEQ_PAUSE_EN
  assign pause_c = pause;
`else
  assign pause_c = 1'b0;
`endif

  // Index of the entry following k in an n-step pattern (wraps to 0).
  function automatic logic [IDX_W-1:0] succ_idx(input logic [IDX_W-1:0] k,
                                                input logic [CNT_W-1:0] n);
    return (({1'b0, k} + CNT_W'(1)) == n) ? '0 : k + IDX_W'(1);
  endfunction

  always_comb begin
    wr_step_c          = '0;
    wr_step_c.enable   = tbl_wr_enable;
    wr_step_c.mode     = tbl_wr_mode;
    wr_step_c.hold     = tbl_wr_hold;
    wr_step_c.duration = SEQ_DUR_W'(tbl_wr_duration);
    wr_step_c.dwell    = SEQ_DUR_W'(tbl_wr_dwell);
  end

  assign wr_ok_c       = tbl_wr_en && (state_q == IDLE);
  assign ns_clamp_c    = (num_steps > CNT_W'(NUM_STEPS)) ? CNT_W'(NUM_STEPS) : num_steps;
  assign step_dur_c    = DUR_W'(ram_q.duration);
  assign step_dw_raw_c = DUR_W'(ram_q.dwell);
  assign step_dwell_c  = (step_dw_raw_c == '0) ? DUR_W'(1) : step_dw_raw_c;
  assign last_step_c   = (({1'b0, cur_q} + CNT_W'(1)) == ns_q);
  assign more_loops_c  = (loops_q == '0) || (({1'b0, loop_cnt_q} + 17'd1) < {1'b0, loops_q});

  // Read address is the next-cycle successor so ram_q always holds the prefetched entry.
  led_seq_step_ram #(
    .DEPTH (NUM_STEPS)
  ) u_ram (
    .clk     (aclk),
    .wr_en   (wr_ok_c),
    .wr_addr (tbl_wr_addr),
    .wr_data (wr_step_c),
    .rd_addr (nxt_d),
    .rd_data (ram_q)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      nxt_q      <= '0;
      ns_q       <= '0;
      loops_q    <= '0;
      loop_cnt_q <= '0;
      dwell_q    <= '0;
      dur_q      <= '0;
      en_q       <= '0;
      mode_q     <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      ns_q       <= ns_d;
      loops_q    <= loops_d;
      loop_cnt_q <= loop_cnt_d;
      dwell_q    <= dwell_d;
      dur_q      <= dur_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      wr_err_q   <= wr_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    ns_d       = ns_q;
    loops_d    = loops_q;
    loop_cnt_d = loop_cnt_q;
    dwell_d    = dwell_q;
    dur_d      = dur_q;
    en_d       = en_q;
    mode_d     = mode_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    wr_err_d   = tbl_wr_en && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        nxt_d = '0;
        if (start && !stop && (ns_clamp_c != '0)) begin
          state_d    = LOAD;
          ns_d       = ns_clamp_c;
          loops_d    = loops;
          loop_cnt_d = '0;
          cur_d      = '0;
        end
      end
      LOAD: begin
        state_d = RUN;
        en_d    = ram_q.enable;
        mode_d  = ram_q.mode;
        hold_d  = ram_q.hold;
        dur_d   = step_dur_c;
        dwell_d = step_dwell_c;
        cur_d   = '0;
        nxt_d   = succ_idx('0, ns_q);
      end
      RUN: begin
        if (!pause_c) begin
          if (dwell_q > DUR_W'(1)) begin
            dwell_d = dwell_q - DUR_W'(1);
          end else if (!last_step_c || more_loops_c) begin
            en_d    = ram_q.enable;
            mode_d  = ram_q.mode;
            hold_d  = ram_q.hold;
            dur_d   = step_dur_c;
            dwell_d = step_dwell_c;
            cur_d   = nxt_q;
            nxt_d   = succ_idx(nxt_q, ns_q);
            if (last_step_c && (loop_cnt_q != '1)) begin
              loop_cnt_d = loop_cnt_q + 16'd1;
            end
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            en_d    = '0;
            mode_d  = '0;
            hold_d  = '0;
            dur_d   = '0;
            cur_d   = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        nxt_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything while a sequence is in flight.
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      done_d  = 1'b0;
      abort_d = 1'b1;
      en_d    = '0;
      mode_d  = '0;
      hold_d  = '0;
      dur_d   = '0;
      cur_d   = '0;
      nxt_d   = '0;
      dwell_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  assign tbl_wr_err = wr_err_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = abort_q;
  assign cur_step   = cur_q;
  assign enable_r   = en_q[0];
  assign enable_g   = en_q[1];
  assign enable_b   = en_q[2];
  assign mode_r     = mode_q[0];
  assign mode_g     = mode_q[1];
  assign mode_b     = mode_q[2];
  assign holded_r   = hold_q[0];
  assign holded_g   = hold_q[1];
  assign holded_b   = hold_q[2];
  assign duration_r = dur_q;
  assign duration_g = dur_q;
  assign duration_b = dur_q;

endmodule

// File: tb/tb_led_rgb_sequencer.sv
// Randomized self-checking bench for led_rgb_sequencer against a per-cycle trace model.
// Builds with or without LED_SEQ_PAUSE_EN.
module tb_led_rgb_sequencer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        tbl_wr_en;
  logic [3:0]  tbl_wr_addr;
  logic [2:0]  tbl_wr_enable, tbl_wr_mode, tbl_wr_hold;
  logic [31:0] tbl_wr_duration, tbl_wr_dwell;
  logic        tbl_wr_err;
  logic [4:0]  num_steps;
  logic [15:0] loops;
  logic        start, stop;
`ifdef LED_SEQ_PAUSE_EN
  logic        pause;
`endif
  logic        busy, done, aborted;
  logic [3:0]  cur_step;
  logic        mode_r, mode_g, mode_b, enable_r, enable_g, enable_b;
  logic        holded_r, holded_g, holded_b;
  logic [31:0] duration_r, duration_g, duration_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference copy of the step table.
  logic [2:0]  m_en [16];
  logic [2:0]  m_mode [16];
  logic [2:0]  m_hold [16];
  logic [31:0] m_dur [16];
  logic [31:0] m_dwell [16];

  always #5 aclk = ~aclk;

  led_rgb_sequencer dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .tbl_wr_en       (tbl_wr_en),
    .tbl_wr_addr     (tbl_wr_addr),
    .tbl_wr_enable   (tbl_wr_enable),
    .tbl_wr_mode     (tbl_wr_mode),
    .tbl_wr_hold     (tbl_wr_hold),
    .tbl_wr_duration (tbl_wr_duration),
    .tbl_wr_dwell    (tbl_wr_dwell),
    .tbl_wr_err      (tbl_wr_err),
    .num_steps       (num_steps),
    .loops           (loops),
    .start           (start),
    .stop            (stop),
`ifdef LED_SEQ_PAUSE_EN
    .pause           (pause),
`endif
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .cur_step        (cur_step),
    .mode_r          (mode_r),
    .mode_g          (mode_g),
    .mode_b          (mode_b),
    .enable_r        (enable_r),
    .enable_g        (enable_g),
    .enable_b        (enable_b),
    .holded_r        (holded_r),
    .holded_g        (holded_g),
    .holded_b        (holded_b),
    .duration_r      (duration_r),
    .duration_g      (duration_g),
    .duration_b      (duration_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Layout: busy[48] done[47] aborted[46] wr_err[45] cur[44:41] en[40:38] mode[37:35] hold[34:32] dur[31:0]
  function automatic logic [63:0] pack_exp(input bit b, input bit d, input bit ab, input bit we,
                                           input int cur, input logic [2:0] en,
                                           input logic [2:0] md, input logic [2:0] hd,
                                           input logic [31:0] dur);
    return {15'd0, b, d, ab, we, 4'(cur), en, md, hd, dur};
  endfunction

  function automatic logic [63:0] obs_vec();
    return {15'd0, busy, done, aborted, tbl_wr_err, cur_step,
            enable_b, enable_g, enable_r, mode_b, mode_g, mode_r,
            holded_b, holded_g, holded_r, duration_r};
  endfunction

  task automatic write_step(input int idx, input logic [2:0] en, input logic [2:0] md,
                            input logic [2:0] hd, input logic [31:0] dur, input logic [31:0] dw);
    tbl_wr_en = 1'b1; tbl_wr_addr = 4'(idx);
    tbl_wr_enable = en; tbl_wr_mode = md; tbl_wr_hold = hd;
    tbl_wr_duration = dur; tbl_wr_dwell = dw;
    @(negedge aclk);
    tbl_wr_en = 1'b0;
    m_en[idx] = en; m_mode[idx] = md; m_hold[idx] = hd; m_dur[idx] = dur; m_dwell[idx] = dw;
    check_eq("wr_err_idle", {63'd0, tbl_wr_err}, 64'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++)
      write_step(i, 3'($urandom), 3'($urandom), 3'($urandom), $urandom,
                 32'($urandom_range(0, 4)));
  endtask

  // Expected outputs per cycle after start: LOAD, each step for max(dwell,1) cycles, DONE, idle.
  task automatic run_seq(input int ns, input int lp, input int stop_at, input int wr_at,
                         input bit noise, input int pause_at, input int pause_len);
    logic [63:0] exp_q[$];
    logic [63:0] tmp;
    int nse, l, len, c, stop_eff, wr_eff;
    nse = (ns > 16) ? 16 : ns;
    exp_q.push_back(64'd0);
    exp_q.push_back(pack_exp(1, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 32'd0));
    l = 0;
    while ((lp == 0) ? (exp_q.size() <= stop_at + 1) : (l < lp)) begin
      for (int s = 0; s < nse; s++) begin
        len = (m_dwell[s] == 0) ? 1 : int'(m_dwell[s]);
        if (l == 0 && s == 0) len += pause_len;
        repeat (len) exp_q.push_back(pack_exp(1, 0, 0, 0, s, m_en[s], m_mode[s], m_hold[s], m_dur[s]));
      end
      l++;
    end
    if (lp != 0) exp_q.push_back(pack_exp(1, 1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 32'd0));
    exp_q.push_back(64'd0);
    stop_eff = -1;
    if (stop_at >= 1 && stop_at < exp_q.size() - 1) begin
      stop_eff = stop_at;
      while (exp_q.size() > stop_at + 1) void'(exp_q.pop_back());
      exp_q.push_back(pack_exp(0, 0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 32'd0));
      exp_q.push_back(64'd0);
    end
    wr_eff = -1;
    if (wr_at >= 1 && wr_at < exp_q.size()) begin
      tmp = exp_q[wr_at];
      if (tmp[48]) begin
        wr_eff = wr_at;
        tmp = exp_q[wr_at + 1];
        tmp[45] = 1'b1;
        exp_q[wr_at + 1] = tmp;
      end
    end

    num_steps = 5'(ns); loops = 16'(lp); start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    c = 1;
    while (c < exp_q.size()) begin
      check_eq("seq", obs_vec(), exp_q[c]);
      tmp = exp_q[c];
      check_eq("dur_gb", {duration_g, duration_b}, {tmp[31:0], tmp[31:0]});
      stop = (c == stop_eff);
      tbl_wr_en = (c == wr_eff);
      if (c == wr_eff) begin
        tbl_wr_addr = 4'($urandom); tbl_wr_enable = 3'($urandom); tbl_wr_mode = 3'($urandom);
        tbl_wr_hold = 3'($urandom); tbl_wr_duration = $urandom; tbl_wr_dwell = 32'd9;
      end
      if (noise && c <= exp_q.size() - 3) begin
        num_steps = 5'($urandom); loops = 16'($urandom); start = 1'($urandom);
      end else begin
        start = 1'b0;
      end
`ifdef LED_SEQ_PAUSE_EN
      pause = (c >= pause_at) && (c < pause_at + pause_len);
`endif
      @(negedge aclk);
      c++;
    end
    stop = 1'b0; tbl_wr_en = 1'b0; start = 1'b0;
`ifdef LED_SEQ_PAUSE_EN
    pause = 1'b0;
`endif
  endtask

  // Start that must be rejected: DUT stays idle with all outputs low.
  task automatic check_idle_start(input int ns, input bit with_stop);
    num_steps = 5'(ns); loops = 16'd1; start = 1'b1; stop = with_stop;
    @(negedge aclk);
    start = 1'b0; stop = 1'b0;
    repeat (3) begin
      check_eq("idle_start", obs_vec(), 64'd0);
      @(negedge aclk);
    end
  endtask

  initial begin
    int lp, stop_at, wr_at;
    aresetn = 1'b0; tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_enable = '0;
    tbl_wr_mode = '0; tbl_wr_hold = '0; tbl_wr_duration = '0; tbl_wr_dwell = '0;
    num_steps = '0; loops = '0; start = 1'b0; stop = 1'b0;
`ifdef LED_SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (3) @(negedge aclk);
    check_eq("reset", obs_vec(), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 16; i++) write_step(i, 3'd0, 3'd0, 3'd0, 32'd0, 32'd1);

    // Basic, looping, infinite with abort.
    write_step(0, 3'b001, 3'b000, 3'b000, 32'd100, 32'd5);
    write_step(1, 3'b010, 3'b010, 3'b100, 32'd200, 32'd3);
    run_seq(2, 1, -1, -1, 0, -1, 0);
    run_seq(2, 3, -1, -1, 0, -1, 0);
    run_seq(2, 0, 22, -1, 0, -1, 0);

    // Zero dwell behaves as one cycle.
    write_step(1, 3'b110, 3'b011, 3'b001, 32'd7, 32'd0);
    run_seq(2, 2, -1, -1, 0, -1, 0);
    write_step(1, 3'b010, 3'b010, 3'b100, 32'd200, 32'd3);

    check_idle_start(0, 1'b0);
    check_idle_start(2, 1'b1);

    // Reset mid-run, table must survive.
    num_steps = 5'd2; loops = 16'd0; start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    repeat (6) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    check_eq("rst_mid", obs_vec(), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check_eq("rst_idle", obs_vec(), 64'd0);
    run_seq(2, 1, -1, -1, 0, -1, 0);

    // Write while busy is dropped.
    run_seq(1, 0, 15, 6, 0, -1, 0);
    run_seq(1, 1, -1, -1, 0, -1, 0);

    // num_steps above depth clamps.
    fill_random();
    run_seq(20, 1, -1, -1, 0, -1, 0);

`ifdef LED_SEQ_PAUSE_EN
    write_step(0, 3'b001, 3'b000, 3'b000, 32'd100, 32'd5);
    write_step(1, 3'b010, 3'b010, 3'b100, 32'd200, 32'd3);
    run_seq(2, 1, -1, -1, 0, 3, 10);
`endif

    for (int it = 0; it < 10; it++) begin
      fill_random();
      lp = $urandom_range(0, 3);
      if (lp == 0) stop_at = $urandom_range(1, 80);
      else stop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : -1;
      wr_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : -1;
      run_seq($urandom_range(1, 20), lp, stop_at, wr_at, 1, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_rgb_sequencer.md
Name: led_rgb_sequencer

Overview:
- Autonomous pattern sequencer that drives the control inputs of the led_rgb datapath (mode, enable, holded and duration per colour).
- Steps through a small programmable step table and repeats the pattern a set number of times or forever.
- Sits between the AXI-Lite register block and led_rgb, so software loads a pattern once instead of rewriting LED registers in real time.

Parameters:
- NUM_STEPS, 16, depth of the step table; power of two, minimum 2.
- DUR_W, 32, width of blink-duration and dwell fields.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- tbl_wr_en  in  1  step-table write strobe
- tbl_wr_addr  in  $clog2(NUM_STEPS)  table index
- tbl_wr_enable  in  3  per-step enable mask {b,g,r}
- tbl_wr_mode  in  3  per-step mode mask {b,g,r} (1 = blink, 0 = steady)
- tbl_wr_hold  in  3  per-step holded mask {b,g,r}
- tbl_wr_duration  in  DUR_W  blink half-period passed to led_rgb
- tbl_wr_dwell  in  DUR_W  step length in cycles
- tbl_wr_err  out  1  one-cycle pulse: write rejected while busy
- num_steps  in  $clog2(NUM_STEPS)+1  active steps; values above NUM_STEPS clamp to NUM_STEPS
- loops  in  16  pattern repetitions; 0 = infinite
- start  in  1  start pulse
- stop  in  1  abort pulse
- busy  out  1  sequence running
- done  out  1  one-cycle pulse on natural completion
- aborted  out  1  one-cycle pulse on stop
- cur_step  out  $clog2(NUM_STEPS)  index of the step currently driven
- mode_r/mode_g/mode_b  out  1 each  to led_rgb
- enable_r/enable_g/enable_b  out  1 each  to led_rgb
- holded_r/holded_g/holded_b  out  1 each  to led_rgb
- duration_r/duration_g/duration_b  out  DUR_W each  to led_rgb; all three equal the step's duration

Behaviour:
- Reset (aresetn=0 at a clock edge): all outputs 0, state IDLE, loop and step counters 0. Table contents are not reset.
- Reset mid-run behaves the same: the next cycle is IDLE with LEDs disabled.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 with num_steps!=0 and stop=0 moves to LOAD; busy=1 from the next cycle.
  - start with num_steps=0 is ignored.
  - start and stop in the same cycle: stop wins and nothing happens.
- LOAD: one cycle; reads table[cur_step]; registered outputs show step 0 two cycles after the start cycle; moves to RUN.
- RUN:
  - Step k outputs stay stable for exactly max(dwell_k,1) cycles, then step k+1 outputs appear. There are no gap cycles between steps: the next entry is prefetched in the last dwell cycle.
  - After step num_steps-1: if loops=0, or the completed-loop count+1 < loops, wrap to step 0 and continue seamlessly; otherwise go to DONE.
- DONE: one cycle. Enables, modes, holds and durations go to 0 and done=1 in that same cycle; next state IDLE, busy=0.
- stop in LOAD/RUN/DONE: next cycle IDLE, all LED outputs 0, aborted=1 for one cycle, done not asserted. stop in IDLE does nothing.
- start while busy is ignored.
- Table writes:
  - Accepted only in IDLE; take effect at the next run.
  - A write while busy is dropped and pulses tbl_wr_err in the following cycle.
- Inputs sampled at run start: num_steps and loops are latched on the accepted start; later changes have no effect until the next run.
- Counter widths:
  - Dwell counter is DUR_W bits and never wraps; dwell 0 is treated as 1.
  - Loop counter is 16 bits and saturates when loops=0.

Optional Feature:
- Macro LED_SEQ_PAUSE_EN.
- When defined, adds input port pause (1 bit):
  - While pause=1 in RUN, the dwell counter and step advance freeze and outputs hold.
  - stop still aborts; start stays ignored.
  - pause in IDLE/LOAD/DONE has no effect.
- When undefined: no pause port, and RUN always counts.

Decomposition:
- Package led_seq_pkg holds:
  - state enum seq_state_t {IDLE, LOAD, RUN, DONE};
  - packed struct seq_step_t {enable[2:0], mode[2:0], hold[2:0], duration[DUR_W-1:0], dwell[DUR_W-1:0]};
  - constants for default NUM_STEPS/DUR_W.
- One sub-module, led_seq_step_ram: single write port, single registered read port, array of seq_step_t, maps to distributed RAM.
- FSM and counters stay in the top.

Test Plan:
- Basic run: step0 {enable=001, dwell=5}, step1 {enable=010, dwell=3}, num_steps=2, loops=1, start.
  - enable_r high cycles 2-6, enable_g high cycles 7-9, done pulses cycle 10 with all enables 0, busy low cycle 11.
- Looping: same table, loops=3 -> exactly 3 r/g alternations, no gap cycles, single done after 24 RUN cycles.
- Abort: loops=0, stop on RUN cycle 20 -> cycle 21 outputs 0, aborted=1, done never asserted, busy=0.
- Edge cases:
  - dwell=0 -> step lasts 1 cycle.
  - num_steps=0 start -> busy stays 0.
  - num_steps=20 with NUM_STEPS=16 -> runs 16 steps.
  - start+stop same cycle -> nothing.
- Write while busy -> tbl_wr_err pulse; table unchanged on the next run (read back via a 1-step run).
- With LED_SEQ_PAUSE_EN: pause 10 cycles mid-step of dwell=5 -> step length becomes 15 cycles, outputs stable throughout.
